// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register carrying a control vector and
// a payload, with an optional second (skid) entry that registers in_ready.
//
// Ports:
//   clk, rst_n   - rising-edge clock, synchronous active-low reset
//   flush        - synchronous kill of every held entry (redirect)
//   in_valid     - upstream offers in_ctrl/in_data
//   in_ready     - stage can accept this cycle (forced low while in reset)
//   in_ctrl      - control bits, zeroed whenever the output is a bubble
//   in_data      - payload, passed through unchanged
//   out_valid    - downstream sees a live entry on out_ctrl/out_data
//   out_ready    - downstream accepts this cycle
//   out_ctrl     - control bits of the head entry, all-zero in a bubble
//   out_data     - payload of the head entry, holds last value in a bubble
//   occ          - number of entries currently held (0..1+SKID)
//
// Parameters:
//   DATA_W - payload width
//   CTRL_W - control vector width
//   SKID   - 0: single entry, in_ready combinational from out_ready
//            1: two entries, in_ready is a flop (no out_ready -> in_ready path)

module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  // Main (head) entry; this is what downstream sees.
  logic              m_vld;
  logic [CTRL_W-1:0] m_ctrl;
  logic [DATA_W-1:0] m_data;

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_vld & out_ready;

  // m_ctrl is kept at zero whenever m_vld is low, so the bubble rule
  // holds straight off the register.
  assign out_valid = m_vld;
  assign out_ctrl  = m_ctrl;
  assign out_data  = m_data;

  if (SKID == 0) begin : g_single

    // Accept when empty or when the current entry leaves this edge.
    assign in_ready = rst_n & (out_ready | ~m_vld);
    assign occ      = {1'b0, m_vld};

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        m_vld  <= 1'b0;
        m_ctrl <= '0;
        m_data <= '0;
      end else if (flush) begin
        m_vld  <= 1'b0;
        m_ctrl <= '0;
      end else if (in_fire) begin
        m_vld  <= 1'b1;
        m_ctrl <= in_ctrl;
        m_data <= in_data;
      end else if (out_fire) begin
        m_vld  <= 1'b0;
        m_ctrl <= '0;
      end
    end

  end else begin : g_skid

    // Skid entry: holds the word that arrived while the head was stalled.
    logic              s_vld;
    logic [CTRL_W-1:0] s_ctrl;
    logic [DATA_W-1:0] s_data;
    logic              rdy_q;

    logic              m_vld_n;
    logic [CTRL_W-1:0] m_ctrl_n;
    logic [DATA_W-1:0] m_data_n;
    logic              s_vld_n;
    logic [CTRL_W-1:0] s_ctrl_n;
    logic [DATA_W-1:0] s_data_n;

    // rdy_q resets high so in_ready rises as soon as rst_n does;
    // the rst_n gate keeps it low during reset.
    assign in_ready = rdy_q & rst_n;
    assign occ      = {m_vld & s_vld, m_vld ^ s_vld};

    always_comb begin
      m_vld_n  = m_vld;
      m_ctrl_n = m_ctrl;
      m_data_n = m_data;
      s_vld_n  = s_vld;
      s_ctrl_n = s_ctrl;
      s_data_n = s_data;
      if (out_fire) begin
        if (s_vld) begin
          // Skid promotes to head; in_ready is low, so no input now.
          m_vld_n  = 1'b1;
          m_ctrl_n = s_ctrl;
          m_data_n = s_data;
          s_vld_n  = 1'b0;
          s_ctrl_n = '0;
        end else if (in_fire) begin
          m_vld_n  = 1'b1;
          m_ctrl_n = in_ctrl;
          m_data_n = in_data;
        end else begin
          m_vld_n  = 1'b0;
          m_ctrl_n = '0;
        end
      end else if (in_fire) begin
        if (m_vld) begin
          s_vld_n  = 1'b1;
          s_ctrl_n = in_ctrl;
          s_data_n = in_data;
        end else begin
          m_vld_n  = 1'b1;
          m_ctrl_n = in_ctrl;
          m_data_n = in_data;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        m_vld  <= 1'b0;
        m_ctrl <= '0;
        m_data <= '0;
        s_vld  <= 1'b0;
        s_ctrl <= '0;
        s_data <= '0;
        rdy_q  <= 1'b1;
      end else if (flush) begin
        m_vld  <= 1'b0;
        m_ctrl <= '0;
        s_vld  <= 1'b0;
        s_ctrl <= '0;
        rdy_q  <= 1'b1;
      end else begin
        m_vld  <= m_vld_n;
        m_ctrl <= m_ctrl_n;
        m_data <= m_data_n;
        s_vld  <= s_vld_n;
        s_ctrl <= s_ctrl_n;
        s_data <= s_data_n;
        rdy_q  <= ~s_vld_n;
      end
    end

  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: two lanes (SKID=0 and SKID=1) driven independently,
// each checked every cycle against a queue model of the stage.

module tb_pipe_stage_reg;

  localparam int DW   = 32;
  localparam int CW   = 8;
  localparam int SOAK = 10000;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  int checks = 0;
  int failures = 0;
  int ndone = 0;

  always #5 clk = ~clk;

  task automatic chk(input int ln, input string nm,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL lane%0d %s: got %0h expected %0h at %0t",
               ln, nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occ;

    ent_t          q[$];
    logic [DW-1:0] got[$];
    logic [DW-1:0] last_d = '0;
    bit            acc = 1'b0;

    pipe_stage_reg #(
      .DATA_W(DW),
      .CTRL_W(CW),
      .SKID(g)
    ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_ctrl(in_ctrl),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_ctrl(out_ctrl),
      .out_data(out_data),
      .occ(occ)
    );

    // Reference: a FIFO of capacity 1+SKID; the single-entry stage may
    // also accept when full if the head leaves on the same edge.
    function automatic bit mready();
      return (rst_n === 1'b1) &&
             (q.size() < 1 + g || (g == 0 && out_ready));
    endfunction

    always @(posedge clk) begin : model
      bit fo;
      bit fi;
      fo = 1'b0;
      fi = 1'b0;
      if (!rst_n) begin
        q.delete();
        last_d = '0;
      end else if (flush) begin
        q.delete();
      end else begin
        fo = q.size() > 0 && out_ready;
        fi = in_valid && mready();
        if (fo) void'(q.pop_front());
        if (fi) q.push_back({in_ctrl, in_data});
      end
      acc = fi;
      if (q.size() > 0) last_d = q[0].d;
    end

    always @(negedge clk) begin : monitor
      chk(g, "occ_bound", occ <= 2'(1 + g), 1);
      chk(g, "occ", occ, q.size());
      chk(g, "in_ready", in_ready, mready());
      chk(g, "out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) begin
        chk(g, "out_ctrl", out_ctrl, q[0].c);
        chk(g, "out_data", out_data, q[0].d);
      end else begin
        chk(g, "bubble_ctrl", out_ctrl, 0);
        chk(g, "hold_data", out_data, last_d);
      end
      if (out_valid && out_ready) got.push_back(out_data);
    end

    task automatic drive(input bit v, input logic [CW-1:0] c,
                         input logic [DW-1:0] d, input bit r, input bit f);
      @(posedge clk);
      #1;
      in_valid  = v;
      in_ctrl   = c;
      in_data   = d;
      out_ready = r;
      flush     = f;
    endtask

    task automatic reset_seq();
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk(g, "rst_valid", out_valid, 0);
      chk(g, "rst_ctrl", out_ctrl, 0);
      chk(g, "rst_data", out_data, 0);
      chk(g, "rst_occ", occ, 0);
      chk(g, "rst_ready", in_ready, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk(g, "rel_ready", in_ready, 1);
    endtask

    task automatic soak(input int n);
      bit pend;
      for (int i = 0; i < n; i++) begin
        @(posedge clk);
        #1;
        // An offer that was neither taken nor flushed must stay put.
        pend = in_valid && !acc && !flush;
        if (!pend) begin
          in_valid = $urandom_range(0, 3) != 0;
          in_ctrl  = CW'($urandom);
          in_data  = $urandom;
        end
        out_ready = $urandom_range(0, 3) != 0;
        flush     = $urandom_range(0, 63) == 0;
        rst_n     = $urandom_range(0, 999) != 0;
      end
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      flush    = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (4) drive(0, '0, '0, 1, 0);
    endtask

    if (g == 1) begin : dir
      initial begin
        int n33;
        reset_seq();

        drive(1, 8'h3F, 32'hA5A5A5A5, 1, 0);
        drive(0, '0, '0, 1, 0);
        @(negedge clk);
        chk(g, "a5_valid", out_valid, 1);
        chk(g, "a5_ctrl", out_ctrl, 8'h3F);
        chk(g, "a5_data", out_data, 32'hA5A5A5A5);
        drive(0, '0, '0, 1, 0);
        @(negedge clk);
        chk(g, "a5_bubble_v", out_valid, 0);
        chk(g, "a5_bubble_c", out_ctrl, 0);

        drive(1, 8'h01, 32'h11, 0, 0);
        drive(1, 8'h02, 32'h22, 0, 0);
        drive(0, '0, '0, 0, 0);
        @(negedge clk);
        chk(g, "full_occ", occ, 2);
        chk(g, "full_ready", in_ready, 0);
        chk(g, "full_head", out_data, 32'h11);
        drive(0, '0, '0, 1, 0);
        @(negedge clk);
        chk(g, "first_out", out_data, 32'h11);
        drive(0, '0, '0, 1, 0);
        @(negedge clk);
        chk(g, "second_out", out_data, 32'h22);
        chk(g, "drain_occ", occ, 1);
        chk(g, "drain_ready", in_ready, 1);
        drive(0, '0, '0, 1, 0);
        @(negedge clk);
        chk(g, "empty_occ", occ, 0);

        drive(1, 8'h0A, 32'hAA, 0, 0);
        drive(1, 8'h0B, 32'hBB, 0, 0);
        drive(1, 8'h07, 32'h33, 0, 1);
        drive(0, '0, '0, 0, 0);
        @(negedge clk);
        chk(g, "fl_occ", occ, 0);
        chk(g, "fl_valid", out_valid, 0);
        chk(g, "fl_ctrl", out_ctrl, 0);
        chk(g, "fl_ready", in_ready, 1);
        repeat (3) drive(0, '0, '0, 1, 0);
        n33 = 0;
        foreach (got[i]) if (got[i] == 32'h33) n33++;
        chk(g, "no_33", n33, 0);

        drive(1, 8'h04, 32'h44, 0, 0);
        drive(0, '0, '0, 0, 0);
        @(negedge clk);
        chk(g, "pre_rst_occ", occ, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk(g, "in_rst_ready", in_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk(g, "mid_rst_valid", out_valid, 0);
        chk(g, "mid_rst_data", out_data, 0);
        chk(g, "mid_rst_occ", occ, 0);
        chk(g, "mid_rst_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk(g, "post_rst_ready", in_ready, 1);

        soak(SOAK);
        ndone++;
      end
    end else begin : dir
      initial begin
        int nxt;
        int cyc;
        reset_seq();
        got.delete();

        nxt = 1;
        cyc = 0;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_ctrl   = 8'h01;
        in_data   = 32'd1;
        out_ready = 1'b0;
        while (cyc < 100 && got.size() < 8) begin
          @(posedge clk);
          #1;
          cyc++;
          if (acc) begin
            if (nxt < 8) begin
              nxt++;
              in_ctrl = CW'(nxt);
              in_data = DW'(nxt);
            end else begin
              in_valid = 1'b0;
            end
          end
          out_ready = ~out_ready;
        end
        in_valid = 1'b0;
        repeat (3) drive(0, '0, '0, 1, 0);
        chk(g, "stream_cnt", got.size(), 8);
        for (int i = 0; i < 8; i++)
          chk(g, "stream_val", i < got.size() ? got[i] : 'x, i + 1);

        soak(SOAK);
        ndone++;
      end
    end
  end

  initial begin
    int cyc;
    cyc = 0;
    while (ndone < 2 && cyc < 60000) begin
      @(posedge clk);
      cyc++;
    end
    chk(9, "timeout", ndone, 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
